// File: rtl/lc3b_types.sv
// Shared victim-cache types: line and tag widths, entry index.
// Pure declarations, no logic.
package lc3b_types;
  localparam int VC_TAGW    = 12;
  localparam int VC_LINEW   = 128;
  localparam int VC_ENTRIES = 16;

  typedef logic [VC_TAGW-1:0]  lc3b_vc_tag;
  typedef logic [VC_LINEW-1:0] lc3b_line;
  typedef logic [3:0]          lc3b_vc_idx;
endpackage

// File: rtl/victim_tag_array.sv
// 16-entry tag/valid/dirty store with a combinational parallel compare.
// Writes land on the next clock edge. A clear on the same entry overrides a write.
module victim_tag_array
  import lc3b_types::*;
#(
  parameter int TAGW = VC_TAGW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TAGW-1:0]               lookup_tag_i,
  input  logic                          wr_en_i,
  input  lc3b_vc_idx                    wr_idx_i,
  input  logic [TAGW-1:0]               wr_tag_i,
  input  logic                          wr_dirty_i,
  input  logic                          clr_en_i,
  input  lc3b_vc_idx                    clr_idx_i,
  output logic                          hit_o,
  output lc3b_vc_idx                    hit_idx_o,
  output logic                          any_invalid_o,
  output lc3b_vc_idx                    first_invalid_o,
  output logic [VC_ENTRIES-1:0]         valid_o,
  output logic [VC_ENTRIES-1:0]         dirty_o,
  output logic [VC_ENTRIES-1:0][TAGW-1:0] tag_o
);

  logic [VC_ENTRIES-1:0][TAGW-1:0] tag_q, tag_d;
  logic [VC_ENTRIES-1:0]           valid_q, valid_d;
  logic [VC_ENTRIES-1:0]           dirty_q, dirty_d;

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en_i) begin
      tag_d[wr_idx_i]   = wr_tag_i;
      dirty_d[wr_idx_i] = wr_dirty_i;
      valid_d[wr_idx_i] = 1'b1;
    end
    if (clr_en_i) begin
      valid_d[clr_idx_i] = 1'b0;
      dirty_d[clr_idx_i] = 1'b0;
    end
  end

  // Tags are not reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q <= tag_d;
  end

  // Descending scan so the lowest matching/invalid index wins.
  always_comb begin
    hit_o           = 1'b0;
    hit_idx_o       = '0;
    any_invalid_o   = 1'b0;
    first_invalid_o = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = 4'(i);
      end
      if (!valid_q[i]) begin
        any_invalid_o   = 1'b1;
        first_invalid_o = 4'(i);
      end
    end
  end

  assign valid_o = valid_q;
  assign dirty_o = dirty_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/victim_cache_control.sv
// Victim cache controller: L1-miss lookup, swap on hit, insert with dirty writeback to L2.
// Response 2 cycles after request on hit/plain miss, longer on insert; L2 writeback stalls on l2_resp.
module victim_cache_control
  import lc3b_types::*;
#(
  parameter int TAGW  = VC_TAGW,
  parameter int LINEW = VC_LINEW
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               l1_req,
  input  logic [TAGW-1:0]                    l1_tag,
  input  logic                               evict_valid,
  input  logic [TAGW-1:0]                    evict_tag,
  input  logic                               evict_dirty,
  input  logic [LINEW-1:0]                   evict_data,
  output logic                               busy,
  output logic                               l1_resp,
  output logic                               l1_hit,
  output logic [LINEW-1:0]                   l1_rdata,
  output logic                               l1_rdirty,
  output logic                               va_write,
  output logic [3:0]                         va_index,
  output logic [LINEW-1:0]                   va_datain,
  input  logic [VC_ENTRIES-1:0][LINEW-1:0]   va_dataout,
  output logic                               l2_write,
  output logic [TAGW-1:0]                    l2_tag,
  output logic [LINEW-1:0]                   l2_wdata,
  input  logic                               l2_resp
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_INSERT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [TAGW-1:0]   req_tag_q, req_tag_d;
  logic              ev_vld_q, ev_vld_d;
  logic [TAGW-1:0]   ev_tag_q, ev_tag_d;
  logic              ev_dirty_q, ev_dirty_d;
  logic [LINEW-1:0]  ev_dat_q, ev_dat_d;
  lc3b_vc_idx        slot_q, slot_d;
  logic              slot_fifo_q, slot_fifo_d;
  lc3b_vc_idx        fifo_ptr_q, fifo_ptr_d;
  logic [LINEW-1:0]  rdata_q, rdata_d;
  logic              rdirty_q, rdirty_d;
  logic              hit_q, hit_d;

  logic                            ta_hit, ta_any_inv, wr_en, clr_en, va_write_c, l2_write_c, l1_resp_c;
  lc3b_vc_idx                      ta_hit_idx, ta_first_inv, wr_idx, victim;
  logic [VC_ENTRIES-1:0]           ta_valid, ta_dirty;
  logic [VC_ENTRIES-1:0][TAGW-1:0] ta_tag;

  victim_tag_array #(.TAGW(TAGW)) u_tags (
    .clk             (clk),
    .rst             (rst),
    .lookup_tag_i    (req_tag_q),
    .wr_en_i         (wr_en),
    .wr_idx_i        (wr_idx),
    .wr_tag_i        (ev_tag_q),
    .wr_dirty_i      (ev_dirty_q),
    .clr_en_i        (clr_en),
    .clr_idx_i       (ta_hit_idx),
    .hit_o           (ta_hit),
    .hit_idx_o       (ta_hit_idx),
    .any_invalid_o   (ta_any_inv),
    .first_invalid_o (ta_first_inv),
    .valid_o         (ta_valid),
    .dirty_o         (ta_dirty),
    .tag_o           (ta_tag)
  );

  assign victim = ta_any_inv ? ta_first_inv : fifo_ptr_q;

  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    ev_vld_d    = ev_vld_q;
    ev_tag_d    = ev_tag_q;
    ev_dirty_d  = ev_dirty_q;
    ev_dat_d    = ev_dat_q;
    slot_d      = slot_q;
    slot_fifo_d = slot_fifo_q;
    fifo_ptr_d  = fifo_ptr_q;
    rdata_d     = rdata_q;
    rdirty_d    = rdirty_q;
    hit_d       = hit_q;
    wr_en       = 1'b0;
    wr_idx      = slot_q;
    clr_en      = 1'b0;
    va_write_c  = 1'b0;
    l2_write_c  = 1'b0;
    l1_resp_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (l1_req) begin
          req_tag_d  = l1_tag;
          ev_vld_d   = evict_valid;
          ev_tag_d   = evict_tag;
          ev_dirty_d = evict_dirty;
          ev_dat_d   = evict_data;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (ta_hit) begin
          rdata_d  = va_dataout[ta_hit_idx];
          rdirty_d = ta_dirty[ta_hit_idx];
          hit_d    = 1'b1;
          if (ev_vld_q) begin
            va_write_c = 1'b1;
            wr_en      = 1'b1;
            wr_idx     = ta_hit_idx;
          end else begin
            clr_en = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          hit_d = 1'b0;
          if (!ev_vld_q) begin
            state_d = S_RESP;
          end else begin
            slot_d      = victim;
            slot_fifo_d = !ta_any_inv;
            state_d     = (ta_valid[victim] && ta_dirty[victim]) ? S_WB : S_INSERT;
          end
        end
      end
      S_WB: begin
        l2_write_c = 1'b1;
        if (l2_resp) state_d = S_INSERT;
      end
      S_INSERT: begin
        va_write_c = 1'b1;
        wr_en      = 1'b1;
        if (slot_fifo_q) fifo_ptr_d = fifo_ptr_q + 4'd1;
        state_d = S_RESP;
      end
      S_RESP: begin
        l1_resp_c = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_tag_q   <= '0;
      ev_vld_q    <= 1'b0;
      ev_tag_q    <= '0;
      ev_dirty_q  <= 1'b0;
      ev_dat_q    <= '0;
      slot_q      <= '0;
      slot_fifo_q <= 1'b0;
      fifo_ptr_q  <= '0;
      rdata_q     <= '0;
      rdirty_q    <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      ev_vld_q    <= ev_vld_d;
      ev_tag_q    <= ev_tag_d;
      ev_dirty_q  <= ev_dirty_d;
      ev_dat_q    <= ev_dat_d;
      slot_q      <= slot_d;
      slot_fifo_q <= slot_fifo_d;
      fifo_ptr_q  <= fifo_ptr_d;
      rdata_q     <= rdata_d;
      rdirty_q    <= rdirty_d;
      hit_q       <= hit_d;
    end
  end

  // Strobes are masked while reset is held so a pending writeback drops immediately.
  assign busy      = !rst && (state_q != S_IDLE);
  assign l1_resp   = !rst && l1_resp_c;
  assign va_write  = !rst && va_write_c;
  assign l2_write  = !rst && l2_write_c;
  assign va_index  = wr_idx;
  assign va_datain = ev_dat_q;
  assign l2_tag    = ta_tag[slot_q];
  assign l2_wdata  = va_dataout[slot_q];
  assign l1_hit    = hit_q;
  assign l1_rdata  = rdata_q;
  assign l1_rdirty = rdirty_q;

endmodule

// File: doc/victim_cache_control.md
VICTIM_CACHE_CONTROL -- requirements
Module: victim_cache_control

Interface
REQ-001 The block SHALL have parameter TAGW, default 12, meaning the line tag width (address[15:4]).
REQ-002 The block SHALL have parameter LINEW, default 128, meaning the cache line width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, as listed in REQ-004 to REQ-005.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port l1_req, input, 1 bit: one-cycle L1-miss lookup pulse.
REQ-007 The block SHALL have port l1_tag, input, TAGW bits: tag of the missing line.
REQ-008 The block SHALL have ports evict_valid (input, 1), evict_tag (input, TAGW), evict_dirty (input, 1) and evict_data (input, LINEW), carrying the line L1 evicts with the request.
REQ-009 The block SHALL have ports busy (output, 1), l1_resp (output, 1; one-cycle done pulse) and l1_hit (output, 1; valid with l1_resp).
REQ-010 The block SHALL have ports l1_rdata (output, LINEW) and l1_rdirty (output, 1), carrying the hit line and its dirty bit.
REQ-011 The block SHALL have ports va_write (output, 1), va_index (output, 4) and va_datain (output, LINEW), driving the data-array write port.
REQ-012 The block SHALL have port va_dataout, input, 16 x LINEW: all data-array entries, read combinationally.
REQ-013 The block SHALL have ports l2_write (output, 1), l2_tag (output, TAGW), l2_wdata (output, LINEW) and l2_resp (input, 1), forming the dirty-victim writeback handshake.

Function
REQ-014 The block SHALL implement the states IDLE, LOOKUP, WB, INSERT and RESP; busy SHALL be 1 in every state except IDLE.
REQ-015 In IDLE, an l1_req pulse SHALL register l1_tag and the evict_* inputs and move to LOOKUP; l1_req SHALL be ignored in all other states.
REQ-016 LOOKUP SHALL take exactly one cycle and compare the registered tag against all 16 entries qualified by their valid bits; at most one entry SHALL match.
REQ-017 On a hit at entry h, the block SHALL capture va_dataout[h] and dirty[h] into l1_rdata and l1_rdirty, using the pre-write value.
REQ-018 On a hit with evict_valid=1, the block SHALL assert va_write at va_index=h in the same cycle and set tag[h]=evict_tag and dirty[h]=evict_dirty (swap).
REQ-019 On a hit with evict_valid=0, the block SHALL clear valid[h].
REQ-020 Every hit SHALL then move to RESP, giving l1_resp two cycles after the cycle in which l1_req was sampled.
REQ-021 On a miss with evict_valid=0, the block SHALL go to RESP with l1_hit=0 and l1_rdata unchanged.
REQ-022 On a miss with evict_valid=1, the victim slot s SHALL be the lowest-index invalid entry; if every entry is valid, s SHALL be fifo_ptr.
REQ-023 If slot s is valid and dirty, the block SHALL go to WB; otherwise it SHALL go to INSERT.
REQ-024 In WB, l2_write SHALL be held at 1 with l2_tag=tag[s] and l2_wdata=va_dataout[s], stable until the cycle l2_resp=1, then the block SHALL go to INSERT.
REQ-025 INSERT SHALL take one cycle: va_write=1 at va_index=s with va_datain=evict_data; tag[s], dirty[s] and valid[s]=1 SHALL update; fifo_ptr SHALL increment mod 16 only when s came from fifo_ptr; then the block SHALL go to RESP with l1_hit=0.
REQ-026 RESP SHALL last one cycle with l1_resp=1, then return to IDLE; l1_rdata, l1_rdirty and l1_hit SHALL stay stable until the next LOOKUP.
REQ-027 va_write SHALL be 0 in all states other than a hit-with-evict LOOKUP and INSERT, and at most one array write SHALL occur per request.
REQ-028 fifo_ptr SHALL wrap from 15 to 0.

Reset
REQ-029 While rst=1, the block SHALL set state=IDLE, clear all valid and dirty bits, set fifo_ptr=0, and drive busy, l1_resp, l1_hit, l1_rdirty, va_write and l2_write to 0 and l1_rdata to 0.
REQ-030 A reset asserted during WB SHALL drop l2_write at the next edge and abandon the writeback.
REQ-031 The block SHALL NOT clear the data array on reset; the valid bits alone SHALL gate its contents.

Structure
REQ-032 The line type (LINEW) and victim tag type (TAGW) SHALL be defined in lc3b_types; the state enum SHALL be local to the block.
REQ-033 A sub-module victim_tag_array SHALL hold the 16 tag/valid/dirty entries with a parallel compare producing hit, hit_index and first_invalid.

Verification
REQ-034 After reset, l1_req with tag 0x123 and evict_valid=0 SHALL yield l1_resp two cycles later with l1_hit=0 and no va_write.
REQ-035 Sixteen misses that evict clean lines with tags 0x000..0x00F SHALL fill slots 0..15 in order, with fifo_ptr remaining 0.
REQ-036 From that full state, a request for tag 0x005 evicting tag 0x100 (data D) SHALL give l1_hit=1 with l1_rdata equal to the old slot-5 data, and slot 5 SHALL then hold tag 0x100 and data D.
REQ-037 From the full state with slot 0 dirty, a miss evicting a line SHALL produce l2_write with l2_tag 0x000; with l2_resp delayed 3 cycles, l2_write SHALL stay high 3 cycles, then slot 0 SHALL be written and fifo_ptr SHALL become 1.
REQ-038 A reset asserted during WB SHALL bring l2_write low next cycle, and the following lookup of tag 0x003 SHALL miss.
REQ-039 An l1_req pulse issued while busy=1 SHALL be ignored, with no extra l1_resp.
